ahb_lite_sram_slave: RTL and testbench
======================================

// Module: ahb_lite_sram_slave
// PURPOSE
//  Parametrised AHB-Lite slave with word-organised on-chip SRAM, programmable wait states,
//  byte-lane writes and two-cycle ERROR response. Sits on the simple_ahb slave side;
//  next-generation slave endpoint replacing fixed-width, zero-wait, error-free slaves.
// PARAMETERS
//  ADDR_WIDTH   12  byte-address width; DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH
//  DATA_WIDTH   32  bus/word width; 32 or 64 only
//  DEPTH        512 storage words; word index >= DEPTH is out of range
//  WAIT_STATES  0   data-phase wait cycles per transfer, 0..15
// PORTS
//  hclk       in   1           bus clock; all state on rising edge
//  hreset     in   1           asynchronous, active-high reset
//  hsel       in   1           slave select (address phase)
//  haddr      in   ADDR_WIDTH  byte address (address phase)
//  htrans     in   2           00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite     in   1           1 write, 0 read
//  hsize      in   3           log2 bytes per transfer
//  hwdata     in   DATA_WIDTH  write data (data phase)
//  hready     in   1           bus-level ready; address phase accepted only when high
//  hreadyout  out  1           slave ready; low inserts wait state
//  hresp      out  1           0 OKAY, 1 ERROR
//  hrdata     out  DATA_WIDTH  read data, valid when hreadyout=1 in read data phase
// BEHAVIOUR
//  Reset (async assert, sync release): hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait
//   counter=0, pending write discarded. SRAM contents not reset.
//  Accept: hsel & hready & htrans[1] at rising edge registers addr/size/write/lane mask.
//   IDLE/BUSY or hsel=0 -> OKAY, zero wait, no access.
//  Error check at accept: word index >= DEPTH, or hsize > log2(DATA_WIDTH/8), or
//   haddr not aligned to hsize -> ERROR path, no SRAM access.
//  FSM: IDLE -> WAIT (accepted OK, WAIT_STATES>0) | DATA (OK, WAIT_STATES=0) | ERR1 (error).
//   WAIT: hreadyout=0, counter decrements; at 0 -> DATA.
//   DATA: hreadyout=1, hresp=0; next state set by address phase sampled this edge.
//   ERR1: hreadyout=0, hresp=1 (one cycle) -> ERR2.
//   ERR2: hreadyout=1, hresp=1; new transfer may be accepted same edge.
//  Latency: data phase lasts 1+WAIT_STATES cycles; back-to-back transfers pipelined.
//  Write: lane mask from hsize & haddr low bits; hwdata bytes committed on edge ending
//   the data phase (hreadyout=1); other bytes unchanged.
//  Read: word fetched at accept (or after waits); hrdata updated on entry to final data
//   cycle and held until next read completes.
//  Hazard: read accepted on edge committing a write to same word -> hrdata must return
//   merged new bytes (forwarding); never stale data.
//  Reset mid-transfer: in-flight write not committed; read data dropped.
//  Data widths: all arithmetic unsigned; word index = haddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
// TESTING
//  1 Assert hreset mid-idle -> hreadyout=1, hresp=0, hrdata=0 asynchronously.
//  2 WS=0: write 0x004=0xDEADBEEF, then read 0x004 back-to-back -> hrdata=0xDEADBEEF,
//    no wait cycles (forwarding path).
//  3 Word 0x008=0x11223344; byte write hsize=0 addr 0x009 hwdata=0x0000AB00 -> read 0x008
//    = 0x1122AB44.
//  4 WS=3: read 0x004 -> hreadyout low 3 cycles, high 4th with 0xDEADBEEF; hresp=0.
//  5 Read 0x800 (word 512) or hsize=2 at 0x002 -> ERR1 (hresp=1,hreadyout=0) then ERR2
//    (hresp=1,hreadyout=1); SRAM unchanged.
//  6 WS=3 write 0x010=0xCAFEF00D, assert hreset in 2nd wait cycle -> hreadyout=1 at once;
//    later read 0x010 returns prior contents.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a word-organised SRAM with programmable wait states,
// byte-lane writes and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 512,
   parameter int WAIT_STATES = 0
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready,
   output logic                  hreadyout,
   output logic                  hresp,
   output logic [DATA_WIDTH-1:0] hrdata
);
   localparam int unsigned NB      = DATA_WIDTH / 8;
   localparam int unsigned BYTE_W  = $clog2(NB);
   localparam int unsigned IDX_W   = ADDR_WIDTH - BYTE_W;
   localparam int unsigned MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned DEPTH_U = DEPTH;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t                state, state_n;
   logic [3:0]            wcnt, wcnt_n;
   logic [MEM_AW-1:0]     addr_r, rd_idx;
   logic [NB-1:0]         lane_r, lane_now;
   logic                  write_r;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0]      idx_now;
   logic                  bad_now, accept, load_addr, load_rd, wr_commit;
   logic [DATA_WIDTH-1:0] commit_word, rd_word;
   logic                  unused_htrans0;

   assign unused_htrans0 = htrans[0];
   assign idx_now        = haddr[ADDR_WIDTH-1:BYTE_W];
   assign accept         = hsel & hready & htrans[1];

   always_comb begin
      int unsigned off, nbytes;
      off      = 32'(haddr[BYTE_W-1:0]);
      nbytes   = 32'd1 << hsize;
      lane_now = '0;
      for (int unsigned b = 0; b < NB; b++)
         lane_now[b] = (b >= off) && (b < off + nbytes);
      bad_now = (32'(idx_now) >= DEPTH_U) || (32'(hsize) > BYTE_W) ||
                ((off & (nbytes - 32'd1)) != 32'd0);
   end

   // The stored word with this cycle's write lanes merged in; also the
   // forwarding source for a read accepted on the committing edge.
   assign wr_commit = (state == S_DATA) && write_r;

   always_comb begin
      commit_word = mem[addr_r];
      for (int unsigned b = 0; b < NB; b++)
         if (lane_r[b]) commit_word[8*b +: 8] = hwdata[8*b +: 8];
   end

   assign rd_idx  = (state == S_WAIT) ? addr_r : MEM_AW'(idx_now);
   assign rd_word = (wr_commit && (rd_idx == addr_r)) ? commit_word : mem[rd_idx];

   always_comb begin
      state_n   = state;
      wcnt_n    = wcnt;
      load_addr = 1'b0;
      load_rd   = 1'b0;
      case (state)
         S_WAIT: begin
            if (wcnt == '0) begin
               state_n = S_DATA;
               load_rd = !write_r;
            end else begin
               wcnt_n = wcnt - 4'd1;
            end
         end
         S_ERR1: state_n = S_ERR2;
         default: begin
            if (accept) begin
               load_addr = 1'b1;
               if (bad_now) begin
                  state_n = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_n = S_WAIT;
                  wcnt_n  = 4'(WAIT_STATES - 1);
               end else begin
                  state_n = S_DATA;
                  load_rd = !hwrite;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         addr_r  <= '0;
         lane_r  <= '0;
         write_r <= 1'b0;
         hrdata  <= '0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
         if (load_addr) begin
            addr_r  <= MEM_AW'(idx_now);
            lane_r  <= lane_now;
            write_r <= hwrite;
         end
         if (load_rd) hrdata <= rd_word;
      end
   end

   always_ff @(posedge hclk) begin
      if (wr_commit) mem[addr_r] <= commit_word;
   end

   assign hreadyout = !((state == S_WAIT) || (state == S_ERR1));
   assign hresp     = (state == S_ERR1) || (state == S_ERR2);

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench: a zero-wait and a three-wait slave share one bus master;
// sel3 routes the transfer and the ready/response mux.
module tb_ahb_lite_sram_slave;
   logic        hclk, hreset, hsel, hwrite, sel3;
   logic [11:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        ro0, ro3, rsp0, rsp3, hready, hresp_m, hsel0, hsel3;
   logic [31:0] rd0, rd3, hrdata_m;

   typedef struct { logic wr; logic [11:0] addr; logic [2:0] size; logic [31:0] wdata; } op_t;
   typedef struct { logic resp; logic wait_resp; int waits; logic chk_rd; logic [31:0] rdata; } res_t;

   op_t  op_q[$];
   res_t exp_q[$];
   res_t obs_q[$];
   int   vectors, miscompares;

   assign hsel0    = hsel & ~sel3;
   assign hsel3    = hsel & sel3;
   assign hready   = sel3 ? ro3 : ro0;
   assign hresp_m  = sel3 ? rsp3 : rsp0;
   assign hrdata_m = sel3 ? rd3 : rd0;

   ahb_lite_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(0)) u_ws0 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
      .hreadyout(ro0), .hresp(rsp0), .hrdata(rd0));

   ahb_lite_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(3)) u_ws3 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
      .hreadyout(ro3), .hresp(rsp3), .hrdata(rd3));

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic queue_xfer(input logic wr, input logic [11:0] a, input logic [2:0] sz,
                             input logic [31:0] wd, input logic err, input logic [31:0] rd);
      int w;
      w = err ? 1 : (sel3 ? 3 : 0);
      op_q.push_back('{wr, a, sz, wd});
      exp_q.push_back('{err, err, w, (!wr && !err), rd});
   endtask

   // Pipelined master: address of the next op goes out while the previous data phase runs.
   task automatic run_ops();
      int          guard, waits;
      bit          pend, dp;
      logic        wresp;
      logic [31:0] pend_wd;
      op_t         o;
      guard = 0; waits = 0; pend = 0; dp = 0; wresp = 1'b0; pend_wd = '0;
      while ((op_q.size() != 0 || pend || dp) && guard < 400) begin
         @(negedge hclk);
         guard++;
         if (pend) begin
            dp = 1; pend = 0; waits = 0; wresp = 1'b0; hwdata = pend_wd;
         end
         if (dp) begin
            if (hready) begin
               obs_q.push_back('{hresp_m, wresp, waits, 1'b0, hrdata_m});
               dp = 0;
            end else begin
               if (waits == 0) wresp = hresp_m;
               waits++;
            end
         end
         if (hready) begin
            if (op_q.size() != 0) begin
               o = op_q.pop_front();
               hsel = 1'b1; htrans = 2'b10; hwrite = o.wr; haddr = o.addr; hsize = o.size;
               pend_wd = o.wdata; pend = 1;
            end else begin
               hsel = 1'b0; htrans = 2'b00;
            end
         end
      end
      vectors++;
      if (guard >= 400) begin
         miscompares++;
         $display("FAIL bus_timeout got %0d cycles required < 400", guard);
         op_q.delete();
      end
      @(negedge hclk);
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (ro0 !== 1'b1)   begin miscompares++; $display("FAIL rst_ready0 got %b exp 1", ro0); end
      vectors++; if (rsp0 !== 1'b0)  begin miscompares++; $display("FAIL rst_resp0 got %b exp 0", rsp0); end
      vectors++; if (rd0 !== 32'h0)  begin miscompares++; $display("FAIL rst_rdata0 got %h exp 0", rd0); end
      vectors++; if (ro3 !== 1'b1)   begin miscompares++; $display("FAIL rst_ready3 got %b exp 1", ro3); end
      vectors++; if (rsp3 !== 1'b0)  begin miscompares++; $display("FAIL rst_resp3 got %b exp 0", rsp3); end
      vectors++; if (rd3 !== 32'h0)  begin miscompares++; $display("FAIL rst_rdata3 got %h exp 0", rd3); end
      repeat (2) @(negedge hclk);
      hreset = 1'b0;
   endtask

   task automatic test_forwarding();
      res_t e, o;
      sel3 = 1'b0;
      queue_xfer(1'b1, 12'h004, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
      queue_xfer(1'b0, 12'h004, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
      run_ops();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++; if (o.resp !== e.resp) begin miscompares++; $display("FAIL fwd_resp got %b exp %b", o.resp, e.resp); end
         vectors++; if (o.waits != e.waits) begin miscompares++; $display("FAIL fwd_waits got %0d exp %0d", o.waits, e.waits); end
         if (e.chk_rd) begin
            vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL fwd_rdata got %h exp %h", o.rdata, e.rdata); end
         end
      end
      vectors++; if (exp_q.size() != obs_q.size()) begin miscompares++; $display("FAIL fwd_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_async_reset_idle();
      @(negedge hclk);
      vectors++; if (rd0 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL held_rdata got %h exp deadbeef", rd0); end
      hreset = 1'b1;
      #1;
      vectors++; if (ro0 !== 1'b1)  begin miscompares++; $display("FAIL arst_ready got %b exp 1", ro0); end
      vectors++; if (rsp0 !== 1'b0) begin miscompares++; $display("FAIL arst_resp got %b exp 0", rsp0); end
      vectors++; if (rd0 !== 32'h0) begin miscompares++; $display("FAIL arst_rdata got %h exp 0", rd0); end
      @(negedge hclk);
      hreset = 1'b0;
   endtask

   task automatic test_byte_lanes();
      res_t e, o;
      sel3 = 1'b0;
      queue_xfer(1'b1, 12'h008, 3'd2, 32'h11223344, 1'b0, 32'h0);
      queue_xfer(1'b1, 12'h009, 3'd0, 32'h0000AB00, 1'b0, 32'h0);
      queue_xfer(1'b0, 12'h008, 3'd2, 32'h0, 1'b0, 32'h1122AB44);
      queue_xfer(1'b1, 12'h00A, 3'd1, 32'h55660000, 1'b0, 32'h0);
      queue_xfer(1'b0, 12'h008, 3'd2, 32'h0, 1'b0, 32'h5566AB44);
      queue_xfer(1'b0, 12'h009, 3'd0, 32'h0, 1'b0, 32'h5566AB44);
      run_ops();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++; if (o.resp !== e.resp) begin miscompares++; $display("FAIL lane_resp got %b exp %b", o.resp, e.resp); end
         vectors++; if (o.waits != e.waits) begin miscompares++; $display("FAIL lane_waits got %0d exp %0d", o.waits, e.waits); end
         if (e.chk_rd) begin
            vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL lane_rdata got %h exp %h", o.rdata, e.rdata); end
         end
      end
      vectors++; if (exp_q.size() != obs_q.size()) begin miscompares++; $display("FAIL lane_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_errors();
      res_t e, o;
      sel3 = 1'b0;
      queue_xfer(1'b1, 12'h000, 3'd2, 32'h0BADF00D, 1'b0, 32'h0);
      queue_xfer(1'b0, 12'h800, 3'd2, 32'h0, 1'b1, 32'h0);
      queue_xfer(1'b1, 12'h002, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
      queue_xfer(1'b1, 12'h000, 3'd3, 32'hFFFFFFFF, 1'b1, 32'h0);
      queue_xfer(1'b1, 12'h001, 3'd1, 32'hFFFFFFFF, 1'b1, 32'h0);
      queue_xfer(1'b0, 12'h000, 3'd2, 32'h0, 1'b0, 32'h0BADF00D);
      run_ops();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++; if (o.resp !== e.resp) begin miscompares++; $display("FAIL err_resp got %b exp %b", o.resp, e.resp); end
         vectors++; if (o.waits != e.waits) begin miscompares++; $display("FAIL err_waits got %0d exp %0d", o.waits, e.waits); end
         vectors++; if (o.wait_resp !== e.wait_resp) begin miscompares++; $display("FAIL err1_resp got %b exp %b", o.wait_resp, e.wait_resp); end
         if (e.chk_rd) begin
            vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL err_rdata got %h exp %h", o.rdata, e.rdata); end
         end
      end
      vectors++; if (exp_q.size() != obs_q.size()) begin miscompares++; $display("FAIL err_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_wait_states();
      res_t e, o;
      sel3 = 1'b1;
      queue_xfer(1'b1, 12'h004, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
      queue_xfer(1'b0, 12'h004, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
      queue_xfer(1'b0, 12'h800, 3'd2, 32'h0, 1'b1, 32'h0);
      queue_xfer(1'b0, 12'h007, 3'd0, 32'h0, 1'b0, 32'hDEADBEEF);
      run_ops();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++; if (o.resp !== e.resp) begin miscompares++; $display("FAIL ws_resp got %b exp %b", o.resp, e.resp); end
         vectors++; if (o.waits != e.waits) begin miscompares++; $display("FAIL ws_waits got %0d exp %0d", o.waits, e.waits); end
         vectors++; if (o.wait_resp !== e.wait_resp) begin miscompares++; $display("FAIL ws_wait_resp got %b exp %b", o.wait_resp, e.wait_resp); end
         if (e.chk_rd) begin
            vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL ws_rdata got %h exp %h", o.rdata, e.rdata); end
         end
      end
      vectors++; if (exp_q.size() != obs_q.size()) begin miscompares++; $display("FAIL ws_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_write();
      res_t e, o;
      sel3 = 1'b1;
      queue_xfer(1'b1, 12'h010, 3'd2, 32'h13579BDF, 1'b0, 32'h0);
      run_ops();
      // Interrupted write: accept, then assert reset during the second wait cycle.
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 12'h010; hsize = 3'd2;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
      vectors++; if (ro3 !== 1'b0) begin miscompares++; $display("FAIL mid_wait_ready got %b exp 0", ro3); end
      @(negedge hclk);
      hreset = 1'b1;
      #1;
      vectors++; if (ro3 !== 1'b1)  begin miscompares++; $display("FAIL mid_rst_ready got %b exp 1", ro3); end
      vectors++; if (rsp3 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_resp got %b exp 0", rsp3); end
      vectors++; if (rd3 !== 32'h0) begin miscompares++; $display("FAIL mid_rst_rdata got %h exp 0", rd3); end
      @(negedge hclk);
      hreset = 1'b0;
      queue_xfer(1'b0, 12'h010, 3'd2, 32'h0, 1'b0, 32'h13579BDF);
      run_ops();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++; if (o.resp !== e.resp) begin miscompares++; $display("FAIL mid_resp got %b exp %b", o.resp, e.resp); end
         vectors++; if (o.waits != e.waits) begin miscompares++; $display("FAIL mid_waits got %0d exp %0d", o.waits, e.waits); end
         if (e.chk_rd) begin
            vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL mid_rdata got %h exp %h", o.rdata, e.rdata); end
         end
      end
      vectors++; if (exp_q.size() != obs_q.size()) begin miscompares++; $display("FAIL mid_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      hreset = 1'b1; sel3 = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      haddr = '0; hsize = 3'd0; hwdata = '0;
      test_reset();
      test_forwarding();
      test_async_reset_idle();
      test_byte_lanes();
      test_errors();
      test_wait_states();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
